// File: rtl/up_wishbone_pipeline.sv
`timescale 1ns/1ps
// Bridges a 32-bit Wishbone slave port onto the uP register request/ack interface.
// Latency: uP request 1 cycle after the accepting edge; s_wb_ack 1 cycle after the uP ack is sampled.
// Backpressure: one transaction in flight; strobes seen outside IDLE are ignored and the uP side may stall indefinitely.
module up_wishbone_pipeline #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_wb_cyc,
    input  logic                     s_wb_stb,
    input  logic                     s_wb_we,
    input  logic [ADDRESS_WIDTH-1:0] s_wb_addr,
    input  logic [31:0]              s_wb_data_i,
    input  logic [3:0]               s_wb_sel,
    output logic                     s_wb_ack,
    output logic [31:0]              s_wb_data_o,
    output logic                     up_rreq,
    input  logic                     up_rack,
    output logic [ADDRESS_WIDTH-3:0] up_raddr,
    input  logic [31:0]              up_rdata,
    output logic                     up_wreq,
    input  logic                     up_wack,
    output logic [ADDRESS_WIDTH-3:0] up_waddr,
    output logic [31:0]              up_wdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic                     accept;
    logic                     rd_done;
    logic                     wr_done;
    logic [31:0]              byte_mask;
    logic                     wb_ack_nxt;
    logic [31:0]              wb_data_nxt;
    logic                     up_rreq_nxt;
    logic                     up_wreq_nxt;
    logic [ADDRESS_WIDTH-3:0] up_raddr_nxt;
    logic [ADDRESS_WIDTH-3:0] up_waddr_nxt;
    logic [31:0]              up_wdata_nxt;

    assign accept    = s_wb_cyc && s_wb_stb;
    assign rd_done   = up_rreq && up_rack;
    assign wr_done   = up_wreq && up_wack;
    assign byte_mask = {{8{s_wb_sel[3]}}, {8{s_wb_sel[2]}}, {8{s_wb_sel[1]}}, {8{s_wb_sel[0]}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            s_wb_ack    <= 1'b0;
            s_wb_data_o <= 32'h0;
            up_rreq     <= 1'b0;
            up_wreq     <= 1'b0;
            up_raddr    <= '0;
            up_waddr    <= '0;
            up_wdata    <= 32'h0;
        end else begin
            state       <= state_nxt;
            s_wb_ack    <= wb_ack_nxt;
            s_wb_data_o <= wb_data_nxt;
            up_rreq     <= up_rreq_nxt;
            up_wreq     <= up_wreq_nxt;
            up_raddr    <= up_raddr_nxt;
            up_waddr    <= up_waddr_nxt;
            up_wdata    <= up_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     if (rd_done || wr_done) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The Wishbone ack is registered on the REQ->ACK edge so it is high exactly during the ACK cycle.
    always_comb begin
        wb_ack_nxt   = 1'b0;
        wb_data_nxt  = s_wb_data_o;
        up_rreq_nxt  = up_rreq;
        up_wreq_nxt  = up_wreq;
        up_raddr_nxt = up_raddr;
        up_waddr_nxt = up_waddr;
        up_wdata_nxt = up_wdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (s_wb_we) begin
                        up_wreq_nxt  = 1'b1;
                        up_waddr_nxt = s_wb_addr[ADDRESS_WIDTH-1:2];
                        up_wdata_nxt = s_wb_data_i & byte_mask;
                    end else begin
                        up_rreq_nxt  = 1'b1;
                        up_raddr_nxt = s_wb_addr[ADDRESS_WIDTH-1:2];
                    end
                end
            end
            REQ: begin
                if (rd_done) begin
                    up_rreq_nxt = 1'b0;
                    wb_data_nxt = up_rdata;
                    wb_ack_nxt  = s_wb_cyc;
                end else if (wr_done) begin
                    up_wreq_nxt = 1'b0;
                    wb_ack_nxt  = s_wb_cyc;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_up_wishbone_pipeline.sv
`timescale 1ns/1ps
// Drives Wishbone transfers into up_wishbone_pipeline against a bench uP decoder model;
// expected uP requests are queued at drive time and popped when each request appears.
module tb_up_wishbone_pipeline;
    logic        tb_data_clk = 1'b0;
    logic        rst_n       = 1'b1;
    logic        s_wb_cyc    = 1'b0;
    logic        s_wb_stb    = 1'b0;
    logic        s_wb_we     = 1'b0;
    logic [15:0] s_wb_addr   = 16'h0;
    logic [31:0] s_wb_data_i = 32'h0;
    logic [3:0]  s_wb_sel    = 4'h0;
    logic        s_wb_ack;
    logic [31:0] s_wb_data_o;
    logic        up_rreq;
    logic        up_rack;
    logic [13:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_wreq;
    logic        up_wack;
    logic [13:0] up_waddr;
    logic [31:0] up_wdata;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        exp_q[$];
    int          checks     = 0;
    int          failures   = 0;
    int          rack_delay = 0;
    int          dec_cnt;
    int          req_rises  = 0;
    int          ack_cnt    = 0;
    int          last_hold  = 0;
    logic [31:0] last_rd    = 32'h0;

    up_wishbone_pipeline #(.ADDRESS_WIDTH(16)) dut (
        .clk         (tb_data_clk),
        .rst         (rst_n),
        .s_wb_cyc    (s_wb_cyc),
        .s_wb_stb    (s_wb_stb),
        .s_wb_we     (s_wb_we),
        .s_wb_addr   (s_wb_addr),
        .s_wb_data_i (s_wb_data_i),
        .s_wb_sel    (s_wb_sel),
        .s_wb_ack    (s_wb_ack),
        .s_wb_data_o (s_wb_data_o),
        .up_rreq     (up_rreq),
        .up_rack     (up_rack),
        .up_raddr    (up_raddr),
        .up_rdata    (up_rdata),
        .up_wreq     (up_wreq),
        .up_wack     (up_wack),
        .up_waddr    (up_waddr),
        .up_wdata    (up_wdata)
    );

    always #5 tb_data_clk = ~tb_data_clk;

    function automatic logic [31:0] mem_rd(input logic [13:0] a);
        case (a)
            14'd0:   return 32'hFEEDBABE;
            14'd1:   return 32'hDEADDEAD;
            14'd2:   return 32'hB0BDBEEF;
            default: return {2'b01, a, 16'hC3C3};
        endcase
    endfunction

    function automatic logic [31:0] bmask(input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Registered uP decoder: acks the pending request rack_delay cycles after first seeing it.
    always @(posedge tb_data_clk or negedge rst_n) begin
        if (!rst_n) begin
            up_rack  <= 1'b0;
            up_wack  <= 1'b0;
            up_rdata <= 32'h0BAD0BAD;
            dec_cnt  <= 0;
        end else begin
            up_rack  <= 1'b0;
            up_wack  <= 1'b0;
            up_rdata <= 32'h0BAD0BAD;
            if ((up_rreq || up_wreq) && !up_rack && !up_wack) begin
                if (dec_cnt >= rack_delay) begin
                    dec_cnt <= 0;
                    if (up_rreq) begin
                        up_rack  <= 1'b1;
                        up_rdata <= mem_rd(up_raddr);
                    end else begin
                        up_wack  <= 1'b1;
                    end
                end else begin
                    dec_cnt <= dec_cnt + 1;
                end
            end
        end
    end

    initial begin : monitor
        req_t cur;
        int   hold;
        logic prev_r;
        logic prev_w;
        cur    = '0;
        hold   = 0;
        prev_r = 1'b0;
        prev_w = 1'b0;
        forever begin
            @(negedge tb_data_clk);
            if (!rst_n) begin
                prev_r = 1'b0;
                prev_w = 1'b0;
                hold   = 0;
            end else begin
                check("no_overlap", 32'(up_rreq & up_wreq), 32'h0);
                if (s_wb_ack) ack_cnt++;
                if ((up_rreq && !prev_r) || (up_wreq && !prev_w)) begin
                    req_rises++;
                    check("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("req_type", 32'(up_wreq), 32'(cur.we));
                        check("req_addr", 32'(up_wreq ? up_waddr : up_raddr), 32'(cur.addr));
                        if (cur.we) check("req_wdata", up_wdata, cur.data);
                    end
                end else if (up_rreq) begin
                    check("raddr_stable", 32'(up_raddr), 32'(cur.addr));
                end else if (up_wreq) begin
                    check("waddr_stable", 32'(up_waddr), 32'(cur.addr));
                    check("wdata_stable", up_wdata, cur.data);
                end
                if (up_rreq) hold++;
                else if (prev_r) begin
                    last_hold = hold;
                    hold      = 0;
                end
                prev_r = up_rreq;
                prev_w = up_wreq;
            end
        end
    end

    // Called at a negedge; returns there one cycle after the ack cycle.
    task automatic wb_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic [31:0] exp_wdat, output int lat);
        req_t e;
        logic got;
        e.we   = we;
        e.addr = addr[15:2];
        e.data = exp_wdat;
        exp_q.push_back(e);
        s_wb_cyc    = 1'b1;
        s_wb_stb    = 1'b1;
        s_wb_we     = we;
        s_wb_addr   = addr;
        s_wb_data_i = wdat;
        s_wb_sel    = sel;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge tb_data_clk);
            if (s_wb_ack) begin
                got = 1'b1;
                lat = i + 1;
                break;
            end
        end
        check("ack_seen", 32'(got), 32'h1);
        s_wb_stb = 1'b0;
        if (got) begin
            if (we) begin
                check("rdata_hold", s_wb_data_o, last_rd);
            end else begin
                check("rdata", s_wb_data_o, mem_rd(addr[15:2]));
                last_rd = mem_rd(addr[15:2]);
            end
            @(negedge tb_data_clk);
            check("ack_pulse", 32'(s_wb_ack), 32'h0);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          lat;
        int          base_r;
        int          base_a;
        logic        seen;
        logic        rw;
        logic [31:0] d;
        logic [3:0]  sel;
        logic [15:0] a;

        #1 rst_n = 1'b0;
        #499;
        check("rst_ack",    32'(s_wb_ack), 32'h0);
        check("rst_data_o", s_wb_data_o,   32'h0);
        check("rst_rreq",   32'(up_rreq),  32'h0);
        check("rst_wreq",   32'(up_wreq),  32'h0);
        check("rst_raddr",  32'(up_raddr), 32'h0);
        check("rst_waddr",  32'(up_waddr), 32'h0);
        check("rst_wdata",  up_wdata,      32'h0);
        @(negedge tb_data_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge tb_data_clk);
        check("idle_rreq", 32'(up_rreq),  32'h0);
        check("idle_wreq", 32'(up_wreq),  32'h0);
        check("idle_ack",  32'(s_wb_ack), 32'h0);

        rack_delay = 0;
        wb_xfer(1'b0, 16'h0008, 32'h0, 4'hF, 32'h0, lat);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_hold", 32'(last_hold), 32'd2);
        check("rd_value", s_wb_data_o, 32'hB0BDBEEF);
        s_wb_cyc = 1'b0;
        @(negedge tb_data_clk);

        wb_xfer(1'b1, 16'h000C, 32'hAAAA0001, 4'hF, 32'hAAAA0001, lat);
        check("wr_latency", 32'(lat), 32'd3);
        wb_xfer(1'b1, 16'h0020, 32'h11223344, 4'b0101, 32'h00220044, lat);
        s_wb_cyc = 1'b0;
        @(negedge tb_data_clk);

        s_wb_cyc = 1'b1;
        base_r = req_rises;
        base_a = ack_cnt;
        a = 16'h0;
        for (int n = 0; n < 24; n++) begin
            rack_delay = int'($urandom_range(0, 2));
            s_wb_stb = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge tb_data_clk);
            rw  = (n < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            d   = $urandom;
            sel = 4'($urandom_range(0, 15));
            wb_xfer(rw, a, d, sel, bmask(d, sel), lat);
            a = a + 16'd4;
        end
        check("stream_reqs", 32'(req_rises - base_r), 32'd24);
        check("stream_acks", 32'(ack_cnt - base_a), 32'd24);
        s_wb_cyc = 1'b0;
        @(negedge tb_data_clk);

        rack_delay = 10;
        wb_xfer(1'b0, 16'h0004, 32'h0, 4'hF, 32'h0, lat);
        check("stall_hold", 32'(last_hold), 32'd12);
        check("stall_latency", 32'(lat), 32'd13);
        s_wb_cyc = 1'b0;
        @(negedge tb_data_clk);

        rack_delay = 3;
        exp_q.push_back('{we: 1'b0, addr: 14'h4, data: 32'h0});
        s_wb_cyc  = 1'b1;
        s_wb_stb  = 1'b1;
        s_wb_we   = 1'b0;
        s_wb_addr = 16'h0010;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge tb_data_clk);
            if (up_rreq) begin
                seen = 1'b1;
                break;
            end
        end
        check("drop_rreq_seen", 32'(seen), 32'h1);
        s_wb_cyc = 1'b0;
        s_wb_stb = 1'b0;
        base_a = ack_cnt;
        repeat (10) @(negedge tb_data_clk);
        check("drop_no_ack", 32'(ack_cnt - base_a), 32'h0);
        check("drop_rreq_done", 32'(up_rreq), 32'h0);
        check("drop_rdata", s_wb_data_o, mem_rd(14'h4));

        rack_delay = 20;
        exp_q.push_back('{we: 1'b0, addr: 14'h5, data: 32'h0});
        s_wb_cyc  = 1'b1;
        s_wb_stb  = 1'b1;
        s_wb_we   = 1'b0;
        s_wb_addr = 16'h0014;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge tb_data_clk);
            if (up_rreq) begin
                seen = 1'b1;
                break;
            end
        end
        check("arst_rreq_seen", 32'(seen), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_rreq",  32'(up_rreq),  32'h0);
        check("arst_wreq",  32'(up_wreq),  32'h0);
        check("arst_ack",   32'(s_wb_ack), 32'h0);
        check("arst_raddr", 32'(up_raddr), 32'h0);
        s_wb_cyc = 1'b0;
        s_wb_stb = 1'b0;
        repeat (3) @(negedge tb_data_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge tb_data_clk);
        check("post_arst_rreq", 32'(up_rreq), 32'h0);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/up_wishbone_pipeline.md
Name: up_wishbone_pipeline

Overview:
Bridges a 32-bit Wishbone slave port to the codebase's simple uP register interface (up_rreq/up_rack, up_wreq/up_wack). Each Wishbone read or write strobe becomes exactly one uP request, held until acknowledged. The uP acknowledge is returned as a single-cycle Wishbone ack. The block sits between a Wishbone interconnect and a peripheral's uP register decoder.

Parameters:
ADDRESS_WIDTH, 16, Wishbone byte-address width. The uP word address is ADDRESS_WIDTH-2 bits wide.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  reset, asynchronous, active-low.
s_wb_cyc  in  1  Wishbone bus cycle valid.
s_wb_stb  in  1  Wishbone strobe.
s_wb_we  in  1  1 = write, 0 = read.
s_wb_addr  in  ADDRESS_WIDTH  byte address.
s_wb_data_i  in  32  write data.
s_wb_sel  in  4  byte selects; bit n covers data[8n+7:8n].
s_wb_ack  out  1  transfer acknowledge, one-cycle pulse.
s_wb_data_o  out  32  read data.
up_rreq  out  1  uP read request.
up_rack  in  1  uP read acknowledge.
up_raddr  out  ADDRESS_WIDTH-2  uP read word address.
up_rdata  in  32  uP read data, valid with up_rack.
up_wreq  out  1  uP write request.
up_wack  in  1  uP write acknowledge.
up_waddr  out  ADDRESS_WIDTH-2  uP write word address.
up_wdata  out  32  uP write data.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state IDLE; s_wb_ack, up_rreq and up_wreq are 0; s_wb_data_o, up_raddr, up_waddr and up_wdata are all 0.
- The FSM has three states: IDLE, REQ, ACK.
- IDLE:
  - A request is accepted on a rising edge where s_wb_cyc=1 and s_wb_stb=1.
  - On acceptance, latch the word address s_wb_addr[ADDRESS_WIDTH-1:2]; the low 2 address bits are ignored.
  - Read (we=0): up_raddr gets the word address; up_rreq goes to 1.
  - Write (we=1): up_waddr gets the word address; up_wdata gets s_wb_data_i with unselected bytes (sel bit = 0) forced to 0; up_wreq goes to 1.
  - Go to REQ.
- REQ:
  - up_rreq or up_wreq stays 1, and address/data stay stable, until the matching ack is sampled 1.
  - There is no timeout.
  - On up_rack=1: capture up_rdata into s_wb_data_o, drop up_rreq, go to ACK.
  - On up_wack=1: drop up_wreq, go to ACK.
  - Acks of the non-requested type are ignored.
- ACK:
  - s_wb_ack=1 for exactly one cycle, but only if s_wb_cyc is still 1.
  - Return to IDLE.
  - No new request is accepted in the ACK cycle.
- Minimum latency with a 1-cycle-ack uP decoder: request asserted 1 cycle after the accepting edge; s_wb_ack 3 cycles after it.
- If s_wb_cyc drops while in REQ, the uP transaction still completes; the Wishbone ack is suppressed.
- s_wb_data_o holds the last read data until the next read completes; writes do not change it.
- Strobes arriving while in REQ or ACK are ignored; the master must re-present them.
- up_rreq and up_wreq are never 1 simultaneously.
- Reset asserted mid-transaction aborts immediately: requests and ack go to 0, state goes to IDLE.

Test Plan:
- Reset: hold rst=0 for 500 ns → every output is 0. Release → block is idle; no request appears while stb=0.
- Single read: cyc=stb=1, we=0, addr=16'h0008; decoder acks after 1 cycle with up_rdata=32'hB0BDBEEF.
  - up_raddr=14'h002.
  - up_rreq is held until up_rack.
  - s_wb_ack is a one-cycle pulse with s_wb_data_o=32'hB0BDBEEF.
- Single write: we=1, addr=16'h000C, data=32'hAAAA0001, sel=4'hF.
  - up_waddr=14'h003, up_wdata=32'hAAAA0001.
  - up_wreq is held until up_wack.
  - One s_wb_ack pulse follows; up_rreq stays 0.
- Byte select: write data=32'h11223344, sel=4'b0101 → up_wdata=32'h00220044.
- Random-stb stream: cyc=1, stb random, address advances by 4 on each (ack & stb).
  - Exactly one uP request per ack.
  - Reads return 32'hFEEDBABE at addr 0 and 32'hDEADDEAD at addr 4.
  - No overlapping requests.
- Abort and stall:
  - Read with up_rack withheld 10 cycles → up_rreq stays 1 for all 10.
  - Drop cyc before the ack → no s_wb_ack.
  - Drive rst=0 while in REQ → up_rreq clears asynchronously.
